sram_write_packer: RTL and testbench
====================================

# sram_write_packer

Packs the 8-bit grayscale pixel stream from the capture front end (VGA capture or static image source) into 32-bit, four-pixel SRAM write commands. Each command is the 54-bit `{mask, addr, data}` word consumed by an SRAM arbiter write port. A start/done four-phase handshake with the swap controller frames exactly one frame of `N_PIXEL` pixels per run. The block sits between the pixel source and the arbiter's W0 input (or the downsampler in front of it).

## Interface
- `N_PIXEL`, 480000: pixels per frame. Must be a multiple of 4, with `N_PIXEL/4 <= 2^18`.
- `BASE_ADDR`, 18'd0: SRAM word address of the first word of the frame.
- `clock` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low. Asserting it clears all state immediately.
- `start` in 1: frame request, four-phase.
- `start_ack` out 1: acknowledge for `start`.
- `done` out 1: frame complete, four-phase.
- `done_ack` in 1: acknowledge for `done`.
- `din` in 8: pixel.
- `din_valid` in 1: `din` is valid.
- `din_ready` out 1: block accepts `din` this cycle.
- `dout` out 54: `{mask[53:50], addr[49:32], data[31:0]}`.
- `valid` out 1: `dout` is valid.
- `ready` in 1: downstream accepts `dout`.

## Operation
- Reset values: `start_ack=0`, `done=0`, `din_ready=0`, `valid=0`, `dout=0`. State is IDLE, lane=0, word count=0.
- State machine:
  - IDLE: `start=1` → ACK.
  - ACK: `start_ack=1`. When `start=0` → RUN and `start_ack` returns to 0. Entering RUN clears lane and word count and sets addr=`BASE_ADDR`.
  - RUN: pixels are packed. When the last word is accepted downstream → DONE.
  - DONE: `done=1`. When `done_ack=1` → DACK.
  - DACK: `done=0`. When `done_ack=0` → IDLE.
- Pixel transfer happens when `din_valid & din_ready`. Pixel k of a word (k = 0..3) goes to `data[8k+7:8k]`, so the first pixel lands in the LSB byte.
- When the 4th pixel is accepted, the output register loads:
  - `data` = the four packed pixels,
  - `addr` = `BASE_ADDR` + word count,
  - `mask` = 4'hF (all bytes written).
- In the same cycle, `valid` is set, lane returns to 0 and the word count increments.
- The output register is single-entry. `valid` clears on `valid & ready` unless a new word loads in the same cycle, in which case `valid` stays 1 with the new contents.
- `din_ready` = (state==RUN) & (words loaded < N_PIXEL/4) & (lane<3 | ~valid | ready).
  - Lanes 0–2 always accept while in RUN.
  - Lane 3 accepts only if the output register is free or draining this cycle.
- Address arithmetic is 18-bit and wraps modulo 2^18. The word count never exceeds N_PIXEL/4 − 1, so addresses within one frame do not overlap.
- After word N_PIXEL/4 − 1 is loaded, `din_ready` stays 0 for the rest of the run. Extra pixels are held off, not dropped.
- `start` seen outside IDLE is ignored. `done_ack` seen outside DONE/DACK is ignored.
- A reset assertion mid-frame returns to IDLE at once. The partial word is discarded and `valid` drops.

## Timing
- `start_ack` rises 1 cycle after `start` is sampled high. It falls 1 cycle after `start` is sampled low. `din_ready` can be 1 in that same cycle.
- Latency: 4th pixel accepted at edge t → `valid=1` with the new `dout` visible after edge t.
- Full throughput is 1 pixel/cycle, with `valid` pulsing every 4th cycle, whenever `ready` is held 1.
- `dout` is stable while `valid & ~ready`.
- `done` rises 1 cycle after the edge on which the last word is accepted (`valid & ready`).
- `done` falls 1 cycle after `done_ack` is sampled high.
- All outputs are registered except `din_ready`, which is combinational from state, lane, `valid` and `ready`.

## Test plan
- Reset and handshake: hold `reset`=0, then release. Check every output is 0.
  - Raise `start`: `start_ack`=1 after 1 cycle.
  - Drop `start`: `start_ack`=0 and `din_ready`=1.
- Packing and address, with N_PIXEL=8, BASE_ADDR=18'h100, pixels 0x01..0x08, `ready`=1:
  - dout = {4'hF, 18'h100, 32'h04030201}, then {4'hF, 18'h101, 32'h08070605}.
  - `done`=1 one cycle after the 2nd word is accepted.
- Backpressure: hold `ready`=0 after the first word.
  - Exactly 3 more pixels are accepted, then `din_ready`=0.
  - `dout` stays unchanged.
  - Releasing `ready` for 1 cycle loads word 2 on that same edge and `valid` stays 1.
- Done four-phase: at `done`=1, assert `done_ack` → `done`=0 next cycle.
  - State stays DACK until `done_ack`=0.
  - A new `start` pulse is then acknowledged, and the next frame restarts at addr 18'h100.
- Overflow hold-off: after the last pixel, keep `din_valid`=1 for 10 cycles.
  - `din_ready` stays 0 and no extra word appears.
- Mid-frame reset: assert `reset`=0 after 6 pixels.
  - `valid`=0 and state is IDLE.
  - After release and a new `start`, the first word carries addr=`BASE_ADDR` and only post-reset pixels.

Source files
------------

// File: rtl/sram_write_packer.sv
// Packs 8-bit pixels into four-pixel {mask, addr, data} SRAM write commands, one frame per start/done handshake.
// Latency: the command is registered on the edge that accepts the 4th pixel; sustains 1 pixel per cycle.
// Backpressure: single-entry output register; only the 4th pixel of a word waits for it to be free or draining.
module sram_write_packer #(
  parameter int          N_PIXEL   = 480000,
  parameter logic [17:0] BASE_ADDR = 18'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        start_ack,
  output logic        done,
  input  logic        done_ack,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [53:0] dout,
  output logic        valid,
  input  logic        ready
);

  // One extra bit so a frame of exactly 2^18 words can still be counted to completion.
  localparam logic [18:0] N_WORDS = 19'(N_PIXEL / 4);

  typedef enum logic [2:0] {IDLE, ACK, RUN, DONE, DACK} state_t;

  state_t      state;
  state_t      state_n;
  logic [1:0]  lane;
  logic [18:0] wcnt;
  logic [7:0]  pix0;
  logic [7:0]  pix1;
  logic [7:0]  pix2;
  logic        take;
  logic        load;
  logic        last_taken;

  // Lanes 0-2 always have room; lane 3 needs the output register free or emptying this cycle.
  assign din_ready  = (state == RUN) && (wcnt < N_WORDS) &&
                      ((lane != 2'd3) || !valid || ready);
  assign take       = din_valid && din_ready;
  assign load       = take && (lane == 2'd3);
  // Once every word has been loaded, the word still in the register is the last one.
  assign last_taken = (wcnt == N_WORDS) && valid && ready;

  // Next-state logic for the start/run/done handshake sequence.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start)      state_n = ACK;
      ACK:     if (!start)     state_n = RUN;
      RUN:     if (last_taken) state_n = DONE;
      DONE:    if (done_ack)   state_n = DACK;
      DACK:    if (!done_ack)  state_n = IDLE;
      default:                 state_n = IDLE;
    endcase
  end

  // State register with handshake outputs registered from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      start_ack <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      start_ack <= (state_n == ACK);
      done      <= (state_n == DONE);
    end
  end

  // Pixel lanes, word counter and the single-entry output command register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane  <= 2'd0;
      wcnt  <= 19'd0;
      pix0  <= 8'd0;
      pix1  <= 8'd0;
      pix2  <= 8'd0;
      dout  <= 54'd0;
      valid <= 1'b0;
    end else begin
      if ((state == ACK) && (state_n == RUN)) begin
        lane <= 2'd0;
        wcnt <= 19'd0;
      end else if (take) begin
        case (lane)
          2'd0:    pix0 <= din;
          2'd1:    pix1 <= din;
          2'd2:    pix2 <= din;
          default: ;
        endcase
        if (lane == 2'd3) begin
          lane <= 2'd0;
          wcnt <= wcnt + 19'd1;
        end else begin
          lane <= lane + 2'd1;
        end
      end

      // A new load wins over draining, so valid stays high back-to-back.
      if (load) begin
        dout  <= {4'hF, BASE_ADDR + wcnt[17:0], din, pix2, pix1, pix0};
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_write_packer.sv
// Self-checking bench for sram_write_packer: table-driven frames, hand-written corner sequences, random frames.
// Expected commands are computed from the pixel source sequence, independent of acceptance timing.
// The bench drives inputs 1 time unit after the rising edge and samples on the falling edge or later in the cycle.
module tb_sram_write_packer;

  localparam int          N_PIXEL   = 8;
  localparam int          N_WORDS   = N_PIXEL / 4;
  localparam logic [17:0] BASE_ADDR = 18'h100;
  localparam int          BUDGET    = 2000;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        start_ack;
  logic        done;
  logic        done_ack;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic [53:0] dout;
  logic        valid;
  logic        ready;

  int errors = 0;
  int checks = 0;

  logic [53:0] got_q[$];
  logic [7:0]  frame_px [N_PIXEL];

  typedef struct {
    logic [63:0] px;    // pixel i in bits [8i+7:8i]
    int          vpct;
    int          rpct;
    logic [53:0] w0;
    logic [53:0] w1;
  } vec_t;

  vec_t vec [3];

  always #5 clock = ~clock;

  sram_write_packer #(
    .N_PIXEL  (N_PIXEL),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .start_ack(start_ack),
    .done     (done),
    .done_ack (done_ack),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .dout     (dout),
    .valid    (valid),
    .ready    (ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference command for word i of the current frame.
  function automatic logic [53:0] exp_word(input int i);
    return {4'hF, BASE_ADDR + 18'(i), frame_px[4*i+3], frame_px[4*i+2], frame_px[4*i+1], frame_px[4*i]};
  endfunction

  // Accepted-command capture plus hold check while stalled.
  logic [53:0] prev_dout = '0;
  bit          prev_stall = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      if (prev_stall) begin
        check("hold_valid", 64'(valid), 64'(1));
        check("hold_dout", 64'(dout), 64'(prev_dout));
      end
      if (valid && ready) got_q.push_back(dout);
      prev_stall = valid && !ready;
      prev_dout  = dout;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic handshake_start();
    start = 1'b1;
    tick();
    check("start_ack_rise", 64'(start_ack), 64'(1));
    start = 1'b0;
    tick();
    check("start_ack_fall", 64'(start_ack), 64'(0));
    #1;
    check("din_ready_run", 64'(din_ready), 64'(1));
  endtask

  // Streams frame_px with random valid/ready duty cycles until done rises.
  task automatic run_frame(input int vpct, input int rpct);
    int idx   = 0;
    int cyc   = 0;
    int taken = 0;
    bit pend;
    bit full;
    full = (vpct >= 100) && (rpct >= 100);
    got_q.delete();
    handshake_start();
    while (!done && cyc < BUDGET) begin
      din       = (idx < N_PIXEL) ? frame_px[idx] : 8'hEE;
      din_valid = (idx >= N_PIXEL) || ($urandom_range(99) < vpct);
      ready     = ($urandom_range(99) < rpct);
      done_ack  = full ? 1'b0 : 1'($urandom_range(1));
      #1;
      if (idx < N_PIXEL && (idx % 4) != 3) check("din_ready_lane", 64'(din_ready), 64'(1));
      if (full && idx < N_PIXEL)           check("full_tput", 64'(din_ready), 64'(1));
      if (idx >= N_PIXEL)                  check("din_ready_holdoff", 64'(din_ready), 64'(0));
      pend = din_valid && din_ready && (idx < N_PIXEL);
      if (valid && ready) taken++;
      tick();
      if (pend) begin
        idx++;
        if (full && (idx % 4) == 0) begin
          check("latency_valid", 64'(valid), 64'(1));
          check("latency_dout", 64'(dout), 64'(exp_word(idx/4 - 1)));
        end
      end
      check("done_timing", 64'(done), 64'(taken == N_WORDS));
      cyc++;
    end
    done_ack  = 1'b0;
    din_valid = 1'b0;
    if (cyc >= BUDGET) check("frame_timeout", 64'(0), 64'(1));
  endtask

  task automatic finish_done();
    check("done_high", 64'(done), 64'(1));
    done_ack = 1'b1;
    tick();
    check("done_fall", 64'(done), 64'(0));
    start = 1'b1;
    repeat (3) tick();
    check("dack_done", 64'(done), 64'(0));
    check("dack_start_ignored", 64'(start_ack), 64'(0));
    start    = 1'b0;
    done_ack = 1'b0;
    tick();
    check("idle_start_ack", 64'(start_ack), 64'(0));
    check("idle_din_ready", 64'(din_ready), 64'(0));
  endtask

  task automatic compare_got(input logic [53:0] e0, input logic [53:0] e1);
    check("word_count", 64'(got_q.size()), 64'(N_WORDS));
    if (got_q.size() >= 1) check("word0", 64'(got_q[0]), 64'(e0));
    if (got_q.size() >= 2) check("word1", 64'(got_q[1]), 64'(e1));
  endtask

  initial begin
    int acc;

    vec[0] = '{px: 64'h08070605_04030201, vpct: 100, rpct: 100,
               w0: {4'hF, 18'h100, 32'h04030201}, w1: {4'hF, 18'h101, 32'h08070605}};
    vec[1] = '{px: 64'h33221100_DDCCBBAA, vpct: 50, rpct: 100,
               w0: {4'hF, 18'h100, 32'hDDCCBBAA}, w1: {4'hF, 18'h101, 32'h33221100}};
    vec[2] = '{px: 64'hFE017F80_00FF00FF, vpct: 100, rpct: 30,
               w0: {4'hF, 18'h100, 32'h00FF00FF}, w1: {4'hF, 18'h101, 32'hFE017F80}};

    reset = 1'b0; start = 1'b0; done_ack = 1'b0;
    din = 8'd0; din_valid = 1'b0; ready = 1'b0;
    repeat (3) tick();
    check("rst_start_ack", 64'(start_ack), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_din_ready", 64'(din_ready), 64'(0));
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_dout", 64'(dout), 64'(0));
    reset = 1'b1;
    tick();
    check("idle_after_rst", 64'(din_ready), 64'(0));

    // Table-driven frames.
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N_PIXEL; i++) frame_px[i] = vec[t].px[8*i +: 8];
      run_frame(vec[t].vpct, vec[t].rpct);
      finish_done();
      compare_got(vec[t].w0, vec[t].w1);
    end

    // Backpressure after the first word, then overflow hold-off with the last word stalled.
    for (int i = 0; i < N_PIXEL; i++) frame_px[i] = 8'h10 + 8'(i);
    got_q.delete();
    handshake_start();
    ready = 1'b1;
    din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = frame_px[i];
      #1;
      check("bp_fill_ready", 64'(din_ready), 64'(1));
      tick();
    end
    check("bp_w0_valid", 64'(valid), 64'(1));
    check("bp_w0_dout", 64'(dout), 64'(exp_word(0)));
    ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      din = frame_px[4 + acc];
      #1;
      if (din_ready) acc++;
      tick();
    end
    check("bp_accept_count", 64'(acc), 64'(3));
    #1;
    check("bp_din_ready", 64'(din_ready), 64'(0));
    check("bp_dout_held", 64'(dout), 64'(exp_word(0)));
    ready = 1'b1;
    din = frame_px[7];
    #1;
    check("bp_release_ready", 64'(din_ready), 64'(1));
    tick();
    check("bp_w1_valid", 64'(valid), 64'(1));
    check("bp_w1_dout", 64'(dout), 64'(exp_word(1)));
    ready = 1'b0;
    din = 8'hEE;
    for (int c = 0; c < 10; c++) begin
      #1;
      check("ovf_din_ready", 64'(din_ready), 64'(0));
      tick();
      check("ovf_dout", 64'(dout), 64'(exp_word(1)));
      check("ovf_done", 64'(done), 64'(0));
    end
    din_valid = 1'b0;
    ready = 1'b1;
    tick();
    check("bp_done", 64'(done), 64'(1));
    check("bp_valid_drained", 64'(valid), 64'(0));
    finish_done();
    compare_got(exp_word(0), exp_word(1));

    // Mid-frame reset after 6 pixels with the first word still pending.
    for (int i = 0; i < N_PIXEL; i++) frame_px[i] = 8'hA0 + 8'(i);
    handshake_start();
    ready = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = frame_px[i];
      #1;
      check("mr_ready", 64'(din_ready), 64'(1));
      tick();
    end
    check("mr_valid_pre", 64'(valid), 64'(1));
    din_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("mr_valid", 64'(valid), 64'(0));
    check("mr_dout", 64'(dout), 64'(0));
    check("mr_din_ready", 64'(din_ready), 64'(0));
    check("mr_start_ack", 64'(start_ack), 64'(0));
    tick();
    reset = 1'b1;
    tick();
    check("mr_idle", 64'(din_ready), 64'(0));

    // Random frames; the first one also proves nothing from the aborted frame survives.
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < N_PIXEL; i++) frame_px[i] = 8'($urandom);
      run_frame(int'($urandom_range(100, 30)), int'($urandom_range(100, 20)));
      finish_done();
      compare_got(exp_word(0), exp_word(1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
